usb_tx_crc16_serializer: RTL and testbench
==========================================

Name: usb_tx_crc16_serializer

Overview:
Transmit-side counterpart of the RX CRC16 checker for USB data packets. Accepts payload bytes over a valid/ready handshake and serializes them LSB-first, one bit per consumer strobe. Computes the USB CRC16 (x^16+x^15+x^2+1) over the transmitted bits and appends the ones-complement CRC field. Sits between the TX FIFO/packet controller and the bit-stuffer/NRZI encoder.

Parameters:
CRC_INIT, 16'hFFFF, CRC register value loaded at packet start
CRC_POLY, 16'h8005, feedback taps (x^15, x^2, x^0)
DATA_W, 8, payload word width; fixed at 8 for USB

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse, begin packet; ignored while busy
zlp  in  1  sampled with start; 1 = zero-length payload, send CRC only
tx_data  in  8  payload byte
data_valid  in  1  tx_data valid
data_last  in  1  qualifies tx_data as final payload byte
data_ready  out  1  holding buffer can accept a byte
shift_en  in  1  downstream consumed serial_out this cycle
serial_out  out  1  current bit to transmit
serial_valid  out  1  serial_out holds a valid bit
busy  out  1  packet in progress (start through done)
done  out  1  one-cycle pulse after last CRC bit consumed
underrun  out  1  one-cycle pulse, payload byte not available when needed

Behaviour:
- Reset (async, any state): state=IDLE, crc=CRC_INIT, shift reg=0, holding buffer empty, bit counter=0; all outputs 0.
- States: IDLE, WAIT_FIRST, SEND_DATA, SEND_CRC.
- IDLE: data_ready=0. start&!zlp -> WAIT_FIRST. start&zlp -> SEND_CRC. Both load crc=CRC_INIT and set busy next cycle.
- Holding buffer: one byte plus last flag. data_ready=1 when buffer empty and state is WAIT_FIRST or SEND_DATA with last byte not yet accepted. Accepted on data_valid&data_ready. Once data_last is accepted, data_ready stays 0 until next packet.
- WAIT_FIRST: when buffer full, move it to shift reg, clear buffer, bitcnt=0 -> SEND_DATA. No timeout.
- SEND_DATA: serial_out=shift_reg[0], serial_valid=1. On shift_en:
  - inv = serial_out ^ crc[15]; crc <= {crc[14:0],1'b0} ^ (inv ? CRC_POLY : 0).
  - Shift reg right by one; bitcnt++.
  - On 8th bit, if current byte is last -> SEND_CRC, bitcnt=0.
  - On 8th bit, else if buffer full -> reload shift reg the same cycle, with no bubble. Simultaneous buffer write and reload is allowed; the reload takes the old buffer contents only if already full.
  - On 8th bit, else -> underrun pulse, done not asserted, -> IDLE, buffer flushed, busy=0.
- SEND_CRC: serial_out=~crc[15], serial_valid=1.
  - On shift_en: crc <= {crc[14:0],1'b1}; bitcnt++. The field goes out MSB first, inverted, with no further CRC update.
  - On 16th bit: done pulses next cycle, -> IDLE, serial_valid=0.
- serial_out/serial_valid are combinational from registered state and change only the cycle after shift_en. shift_en while serial_valid=0 is ignored.
- busy=1 from the cycle after accepted start through the cycle done or underrun is asserted.
- Cycle latency: first bit valid 1 cycle after the first byte is written in WAIT_FIRST. No bubble between consecutive bits regardless of shift_en spacing (minimum spacing 1 cycle).
- Property: feeding every consumed bit into the RX checker leaves its register at residue 16'h800D.

Decomposition:
- Shared package usb_tx_pkg: state enum, USB_CRC16_INIT=16'hFFFF, USB_CRC16_POLY=16'h8005, USB_CRC16_RESIDUE=16'h800D.
- One natural sub-module: tx_crc16_core (crc register, init/update/shift-out controls, inverted MSB output). Holding buffer and FSM stay in the top.

Test Plan:
1. start, zlp=1, shift_en every cycle -> 16 bits all 0 (~FFFF), done pulse after 16th, data_ready never 1.
2. Payload 00 01 02 03, shift_en every 4 cycles, bytes written promptly:
   - Serial data bits match LSB-first payload.
   - CRC field matches the bit-serial model.
   - RX checker residue = 16'h800D.
   - 48 shift_en total, done=1.
3. Single byte 8'hA5 with data_last, shift_en every cycle:
   - Bits 1,0,1,0,0,1,0,1, then 16 CRC bits, with no gaps in serial_valid.
4. Two-byte packet, second byte withheld past the 8th shift_en -> underrun pulse, busy=0 and serial_valid=0 next cycle, no done.
5. rst asserted mid-SEND_CRC:
   - All outputs 0 immediately (async).
   - A new packet after rst deasserts produces a correct CRC (state fully cleared).
6. start pulsed while busy, and shift_en asserted in IDLE -> no effect. Bit stream and done identical to an undisturbed run.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit CRC16 path.
// Holds the serializer state encoding and the CRC16 polynomial constants.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        SEND_DATA  = 2'd2,
        SEND_CRC   = 2'd3
    } tx_state_e;

    localparam logic [15:0] USB_CRC16_INIT    = 16'hFFFF;
    localparam logic [15:0] USB_CRC16_POLY    = 16'h8005;
    localparam logic [15:0] USB_CRC16_RESIDUE = 16'h800D;

    function automatic logic [15:0] crc16_step(
        input logic [15:0] crc,
        input logic        b,
        input logic [15:0] poly
    );
        return {crc[14:0], 1'b0} ^ ((b ^ crc[15]) ? poly : 16'h0000);
    endfunction

endpackage

// File: rtl/tx_crc16_core.sv
// USB CRC16 register: init, bit-serial update over payload,
// then shift-out of the inverted field MSB first.
module tx_crc16_core
    import usb_tx_pkg::*;
#(
    parameter logic [15:0] CRC_INIT = USB_CRC16_INIT,
    parameter logic [15:0] CRC_POLY = USB_CRC16_POLY
) (
    input  logic clk,
    input  logic rst,
    input  logic init,
    input  logic update,
    input  logic data_bit,
    input  logic shift_out,
    output logic crc_bit
);

    logic [15:0] crc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= CRC_INIT;
        end else if (init) begin
            crc_q <= CRC_INIT;
        end else if (update) begin
            crc_q <= crc16_step(crc_q, data_bit, CRC_POLY);
        end else if (shift_out) begin
            crc_q <= {crc_q[14:0], 1'b1};
        end
    end

    assign crc_bit = ~crc_q[15];

endmodule

// File: rtl/usb_tx_crc16_serializer.sv
// USB TX serializer: byte handshake in, LSB-first bits out,
// followed by the inverted CRC16 field.
module usb_tx_crc16_serializer
    import usb_tx_pkg::*;
#(
    parameter logic [15:0] CRC_INIT = USB_CRC16_INIT,
    parameter logic [15:0] CRC_POLY = USB_CRC16_POLY,
    parameter int          DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              zlp,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              data_valid,
    input  logic              data_last,
    output logic              data_ready,
    input  logic              shift_en,
    output logic              serial_out,
    output logic              serial_valid,
    output logic              busy,
    output logic              done,
    output logic              underrun
);

    tx_state_e state_q, state_d;

    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] buf_q;
    logic              buf_full_q;
    logic              buf_last_q;
    logic              cur_last_q;
    logic              last_taken_q;
    logic [3:0]        bitcnt_q;
    logic              busy_q;
    logic              done_q;
    logic              underrun_q;

    logic start_ok;
    logic accept;
    logic consume;
    logic byte_end;
    logic crc_end;
    logic load_first;
    logic data_consume;
    logic crc_consume;
    logic reload;
    logic underrun_d;
    logic crc_bit;

    assign start_ok     = start & (state_q == IDLE) & ~busy_q;
    assign accept       = data_valid & data_ready;
    assign consume      = shift_en & serial_valid;
    assign byte_end     = bitcnt_q == 4'(DATA_W - 1);
    assign crc_end      = bitcnt_q == 4'd15;
    assign load_first   = (state_q == WAIT_FIRST) & buf_full_q;
    assign data_consume = consume & (state_q == SEND_DATA);
    assign crc_consume  = consume & (state_q == SEND_CRC);
    assign reload       = data_consume & byte_end & ~cur_last_q & buf_full_q;
    assign underrun_d   = data_consume & byte_end & ~cur_last_q & ~buf_full_q;

    tx_crc16_core #(
        .CRC_INIT (CRC_INIT),
        .CRC_POLY (CRC_POLY)
    ) u_crc (
        .clk       (clk),
        .rst       (rst),
        .init      (start_ok),
        .update    (data_consume),
        .data_bit  (shift_q[0]),
        .shift_out (crc_consume),
        .crc_bit   (crc_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = zlp ? SEND_CRC : WAIT_FIRST;
                end
            end
            WAIT_FIRST: begin
                if (buf_full_q) begin
                    state_d = SEND_DATA;
                end
            end
            SEND_DATA: begin
                if (consume && byte_end) begin
                    if (cur_last_q) begin
                        state_d = SEND_CRC;
                    end else if (!buf_full_q) begin
                        state_d = IDLE;
                    end
                end
            end
            SEND_CRC: begin
                if (consume && crc_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_ready   = 1'b0;
        serial_valid = 1'b0;
        serial_out   = 1'b0;
        unique case (state_q)
            IDLE: begin
                data_ready = 1'b0;
            end
            WAIT_FIRST: begin
                data_ready = ~buf_full_q & ~last_taken_q;
            end
            SEND_DATA: begin
                data_ready   = ~buf_full_q & ~last_taken_q;
                serial_valid = 1'b1;
                serial_out   = shift_q[0];
            end
            SEND_CRC: begin
                serial_valid = 1'b1;
                serial_out   = crc_bit;
            end
            default: begin
                data_ready = 1'b0;
            end
        endcase
    end

    // Shift register and bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q    <= '0;
            cur_last_q <= 1'b0;
            bitcnt_q   <= 4'd0;
        end else if (start_ok) begin
            bitcnt_q <= 4'd0;
        end else if (load_first || reload) begin
            shift_q    <= buf_q;
            cur_last_q <= buf_last_q;
            bitcnt_q   <= 4'd0;
        end else if (data_consume) begin
            shift_q  <= shift_q >> 1;
            bitcnt_q <= byte_end ? 4'd0 : bitcnt_q + 4'd1;
        end else if (crc_consume) begin
            bitcnt_q <= crc_end ? 4'd0 : bitcnt_q + 4'd1;
        end
    end

    // A write landing on an underrun edge is dropped with the flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q        <= '0;
            buf_full_q   <= 1'b0;
            buf_last_q   <= 1'b0;
            last_taken_q <= 1'b0;
        end else if (start_ok) begin
            buf_full_q   <= 1'b0;
            last_taken_q <= 1'b0;
        end else if (underrun_d) begin
            buf_full_q <= 1'b0;
        end else if (accept) begin
            buf_q        <= tx_data;
            buf_last_q   <= data_last;
            buf_full_q   <= 1'b1;
            last_taken_q <= data_last;
        end else if (load_first || reload) begin
            buf_full_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            done_q     <= crc_consume & crc_end;
            underrun_q <= underrun_d;
            if (start_ok) begin
                busy_q <= 1'b1;
            end else if (done_q || underrun_q) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_usb_tx_crc16_serializer.sv
// Directed bench for the USB TX CRC16 serializer.
// Streams are checked bit by bit and against the CRC16 residue.
module tb_usb_tx_crc16_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       zlp = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_last = 1'b0;
    logic       shift_en = 1'b0;
    logic       data_ready;
    logic       serial_out;
    logic       serial_valid;
    logic       busy;
    logic       done;
    logic       underrun;

    int total = 0;
    int bad = 0;

    logic [7:0] pay [0:3];
    bit bits[$];
    bit exp_q[$];
    bit ref_q[$];
    int done_cnt;
    int undr_cnt;
    int gaps;
    bit ready_seen;
    bit timed_out;
    bit sv_end;
    bit busy_end;

    usb_tx_crc16_serializer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .zlp          (zlp),
        .tx_data      (tx_data),
        .data_valid   (data_valid),
        .data_last    (data_last),
        .data_ready   (data_ready),
        .shift_en     (shift_en),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .busy         (busy),
        .done         (done),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic build_exp(input int n);
        logic [15:0] c;
        bit b;
        c = 16'hFFFF;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 8; j++) begin
                b = pay[i][j];
                exp_q.push_back(b);
                c = {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h8005 : 16'h0000);
            end
        end
        for (int k = 15; k >= 0; k--) begin
            exp_q.push_back(~c[k]);
        end
    endtask

    function automatic logic [15:0] rx_residue();
        logic [15:0] r;
        r = 16'hFFFF;
        foreach (bits[i]) begin
            r = {r[14:0], 1'b0} ^ ((bits[i] ^ r[15]) ? 16'h8005 : 16'h0000);
        end
        return r;
    endfunction

    task automatic run_pkt(input int n, input bit z, input int period,
                           input int hold_idx, input int abort_n,
                           input int poke_cyc);
        int idx;
        int cyc;
        bit acc;
        bit seen_valid;
        idx = 0;
        cyc = 0;
        seen_valid = 0;
        bits.delete();
        done_cnt = 0;
        undr_cnt = 0;
        gaps = 0;
        ready_seen = 0;
        timed_out = 0;
        sv_end = 0;
        busy_end = 0;
        @(negedge clk);
        start = 1'b1;
        zlp = z;
        @(negedge clk);
        start = 1'b0;
        zlp = 1'b0;
        while (1) begin
            if (cyc >= 3000) begin
                timed_out = 1;
                break;
            end
            if (abort_n >= 0 && bits.size() == abort_n) break;
            if (done || underrun) begin
                done_cnt += int'(done);
                undr_cnt += int'(underrun);
                sv_end = serial_valid;
                busy_end = busy;
                break;
            end
            if (seen_valid && !serial_valid) gaps++;
            if (serial_valid) seen_valid = 1;
            if (data_ready) ready_seen = 1;
            data_valid = (idx < n) && (idx != hold_idx);
            tx_data = pay[(idx < 4) ? idx : 0];
            data_last = (idx == n - 1);
            start = (cyc == poke_cyc);
            zlp = start;
            shift_en = (cyc % period) == 0;
            acc = data_valid && data_ready;
            if (shift_en && serial_valid) bits.push_back(serial_out);
            @(negedge clk);
            cyc++;
            if (acc) idx++;
        end
        start = 1'b0;
        zlp = 1'b0;
        shift_en = 1'b0;
        data_valid = 1'b0;
        data_last = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({data_ready, serial_out, serial_valid, busy, done, underrun} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=000000",
                     {data_ready, serial_out, serial_valid, busy, done, underrun});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({data_ready, serial_out, serial_valid, busy, done, underrun} !== 6'b0) begin
            bad++;
            $display("FAIL idle_outputs got=%b want=000000",
                     {data_ready, serial_out, serial_valid, busy, done, underrun});
        end
    endtask

    task automatic test_zlp();
        int ones;
        run_pkt(0, 1'b1, 1, -1, -1, -1);
        total++;
        if (timed_out) begin
            bad++;
            $display("FAIL zlp_timeout got=1 want=0");
        end
        ones = 0;
        foreach (bits[i]) ones += int'(bits[i]);
        total++;
        if (bits.size() != 16 || ones != 0) begin
            bad++;
            $display("FAIL zlp_bits got=%0d bits/%0d ones want=16/0", bits.size(), ones);
        end
        total++;
        if (done_cnt != 1 || busy_end !== 1'b1) begin
            bad++;
            $display("FAIL zlp_done got=%0d/%0b want=1/1", done_cnt, busy_end);
        end
        total++;
        if (ready_seen !== 1'b0) begin
            bad++;
            $display("FAIL zlp_ready got=%0b want=0", ready_seen);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL zlp_after got=%0b%0b want=00", busy, done);
        end
    endtask

    task automatic test_multi_byte();
        int miss;
        pay[0] = 8'h00;
        pay[1] = 8'h01;
        pay[2] = 8'h02;
        pay[3] = 8'h03;
        build_exp(4);
        run_pkt(4, 1'b0, 4, -1, -1, -1);
        total++;
        if (timed_out || bits.size() != 48) begin
            bad++;
            $display("FAIL multi_count got=%0d want=48", bits.size());
        end
        miss = 0;
        foreach (exp_q[i]) begin
            if (i >= bits.size() || bits[i] != exp_q[i]) miss++;
        end
        total++;
        if (miss != 0) begin
            bad++;
            $display("FAIL multi_bits got=%0d wrong want=0", miss);
        end
        total++;
        if (rx_residue() !== 16'h800D) begin
            bad++;
            $display("FAIL multi_residue got=%h want=800d", rx_residue());
        end
        total++;
        if (done_cnt != 1 || undr_cnt != 0 || gaps != 0) begin
            bad++;
            $display("FAIL multi_flags got=%0d/%0d/%0d want=1/0/0", done_cnt, undr_cnt, gaps);
        end
        @(negedge clk);
    endtask

    task automatic test_single_byte();
        logic [7:0] got;
        int miss;
        pay[0] = 8'hA5;
        build_exp(1);
        run_pkt(1, 1'b0, 1, -1, -1, -1);
        got = 8'h00;
        for (int j = 0; j < 8; j++) begin
            if (j < bits.size()) got[j] = bits[j];
        end
        total++;
        if (got !== 8'hA5) begin
            bad++;
            $display("FAIL single_data got=%h want=a5", got);
        end
        miss = 0;
        foreach (exp_q[i]) begin
            if (i >= bits.size() || bits[i] != exp_q[i]) miss++;
        end
        total++;
        if (timed_out || bits.size() != 24 || miss != 0) begin
            bad++;
            $display("FAIL single_stream got=%0d bits/%0d wrong want=24/0", bits.size(), miss);
        end
        total++;
        if (rx_residue() !== 16'h800D) begin
            bad++;
            $display("FAIL single_residue got=%h want=800d", rx_residue());
        end
        total++;
        if (gaps != 0 || done_cnt != 1) begin
            bad++;
            $display("FAIL single_gaps got=%0d/%0d want=0/1", gaps, done_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_underrun();
        pay[0] = 8'h11;
        pay[1] = 8'h22;
        run_pkt(2, 1'b0, 1, 1, -1, -1);
        total++;
        if (timed_out || undr_cnt != 1 || done_cnt != 0) begin
            bad++;
            $display("FAIL underrun_pulse got=%0d/%0d want=1/0", undr_cnt, done_cnt);
        end
        total++;
        if (bits.size() != 8) begin
            bad++;
            $display("FAIL underrun_bits got=%0d want=8", bits.size());
        end
        total++;
        if (sv_end !== 1'b0 || busy_end !== 1'b1) begin
            bad++;
            $display("FAIL underrun_cycle got=%0b%0b want=01", sv_end, busy_end);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || serial_valid !== 1'b0 || underrun !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL underrun_after got=%0b%0b%0b%0b want=0000",
                     busy, serial_valid, underrun, done);
        end
    endtask

    task automatic test_reset_mid();
        int miss;
        pay[0] = 8'h3C;
        run_pkt(1, 1'b0, 1, -1, 13, -1);
        total++;
        if (timed_out || serial_valid !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL midcrc_pre got=%0b%0b want=11", serial_valid, busy);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({data_ready, serial_out, serial_valid, busy, done, underrun} !== 6'b0) begin
            bad++;
            $display("FAIL midcrc_async got=%b want=000000",
                     {data_ready, serial_out, serial_valid, busy, done, underrun});
        end
        @(negedge clk);
        rst = 1'b0;
        pay[0] = 8'h00;
        pay[1] = 8'h01;
        pay[2] = 8'h02;
        pay[3] = 8'h03;
        build_exp(4);
        run_pkt(4, 1'b0, 1, -1, -1, -1);
        miss = 0;
        foreach (exp_q[i]) begin
            if (i >= bits.size() || bits[i] != exp_q[i]) miss++;
        end
        total++;
        if (timed_out || bits.size() != 48 || miss != 0) begin
            bad++;
            $display("FAIL midcrc_next got=%0d bits/%0d wrong want=48/0", bits.size(), miss);
        end
        total++;
        if (rx_residue() !== 16'h800D || done_cnt != 1) begin
            bad++;
            $display("FAIL midcrc_residue got=%h/%0d want=800d/1", rx_residue(), done_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore();
        int miss;
        pay[0] = 8'hC3;
        pay[1] = 8'h5A;
        build_exp(2);
        run_pkt(2, 1'b0, 2, -1, -1, -1);
        ref_q = bits;
        @(negedge clk);
        shift_en = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (serial_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL idle_shift got=%0b%0b%0b want=000", serial_valid, busy, done);
        end
        shift_en = 1'b0;
        run_pkt(2, 1'b0, 2, -1, -1, 6);
        miss = 0;
        foreach (ref_q[i]) begin
            if (i >= bits.size() || bits[i] != ref_q[i]) miss++;
        end
        total++;
        if (timed_out || bits.size() != ref_q.size() || miss != 0) begin
            bad++;
            $display("FAIL busy_start got=%0d bits/%0d wrong want=%0d/0",
                     bits.size(), miss, ref_q.size());
        end
        miss = 0;
        foreach (exp_q[i]) begin
            if (i >= bits.size() || bits[i] != exp_q[i]) miss++;
        end
        total++;
        if (bits.size() != 32 || miss != 0 || done_cnt != 1) begin
            bad++;
            $display("FAIL busy_stream got=%0d/%0d/%0d want=32/0/1", bits.size(), miss, done_cnt);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_zlp();
        test_multi_byte();
        test_single_byte();
        test_underrun();
        test_reset_mid();
        test_ignore();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
